// File: rtl/apb3_regbank.sv
// apb3_regbank: APB3 register bank (PCLK/PRESETn, APB3 slave, SETSIG out, MONSIG in, IRQ out)
module apb3_regbank #(
  parameter int NUM_CH = 4,
  parameter int DW = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int SYNC_STAGES = 2,
  parameter logic [DW-1:0] INIT_SET = '0,
  parameter int FF_DELAY = 1
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [31:0]          PADDR,
  input  logic [31:0]          PWDATA,
  input  logic                 PWRITE,
  input  logic                 PENABLE,
  input  logic                 PSEL,
  output logic [31:0]          PRDATA,
  output logic                 PSLVERR,
  output logic                 PREADY,
  output logic [NUM_CH*DW-1:0] SETSIG,
  input  logic [NUM_CH*DW-1:0] MONSIG,
  output logic                 IRQ
);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  localparam logic [5:0] NCH = 6'(NUM_CH);
  localparam logic [31:0] INFO = {8'hA3, 8'(WAIT_CYCLES), 8'(DW), 8'(NUM_CH)};
  typedef enum logic [1:0] {IDLE, SETUP, WAIT, LAST} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] prdata_q, rd_data;
  logic [NUM_CH-1:0][DW-1:0] set_q, mon_s, prev_q;
  logic [NUM_CH-1:0] status_q, enable_q, chg;
  logic irq_q, arm_q;
  logic setup_ph, access, done, ready, err, wr_commit;
  logic set_hit, mon_hit, st_hit, en_hit, info_hit;
  logic [11:0] a;
  logic [5:0] idx;
  logic unused_ok;
  assign unused_ok = ^{PADDR[31:12], PWDATA, 1'(FF_DELAY)};
  assign a = PADDR[11:0];
  assign idx = a[7:2];
  assign set_hit = a[11:8] == 4'h0 && a[1:0] == 2'b00 && idx < NCH;
  assign mon_hit = a[11:8] == 4'h1 && a[1:0] == 2'b00 && idx < NCH;
  assign st_hit = a == 12'h200;
  assign en_hit = a == 12'h204;
  assign info_hit = a == 12'h208;
  assign err = !(set_hit || mon_hit || st_hit || en_hit || info_hit) || (PWRITE && (mon_hit || info_hit));
  assign setup_ph = PSEL & ~PENABLE;
  assign access = PSEL & PENABLE;
  assign done = (state_q == SETUP && WC == 4'd0) || (state_q == WAIT && cnt_q == WC);
  assign ready = !access || state_q == IDLE || state_q == LAST || done;
  assign wr_commit = access && ready && PWRITE && !err;
  assign PREADY = ready;
  assign PSLVERR = access && ready && err;
  assign PRDATA = prdata_q;
  assign SETSIG = set_q;
  assign IRQ = irq_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = setup_ph ? SETUP : IDLE;
      SETUP: begin
        state_d = !PSEL ? IDLE : WC == 4'd0 ? LAST : WAIT;
        cnt_d = 4'd1;
      end
      WAIT: begin
        state_d = !PSEL ? IDLE : cnt_q == WC ? LAST : WAIT;
        cnt_d = cnt_q + 4'd1;
      end
      LAST: state_d = setup_ph ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (set_hit && idx == 6'(i)) rd_data[DW-1:0] = set_q[i];
      if (mon_hit && idx == 6'(i)) rd_data[DW-1:0] = mon_s[i];
    end
    if (st_hit) rd_data[NUM_CH-1:0] = status_q;
    if (en_hit) rd_data[NUM_CH-1:0] = enable_q;
    if (info_hit) rd_data = INFO;
  end
  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_CH; i++) chg[i] = arm_q && mon_s[i] != prev_q[i];
  end
  if (SYNC_STAGES == 0) begin : g_nosync
    assign mon_s = MONSIG;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][NUM_CH*DW-1:0] sync_q;
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= MONSIG;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign mon_s = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      prdata_q <= '0;
      set_q <= {NUM_CH{INIT_SET}};
      status_q <= '0;
      enable_q <= '0;
      irq_q <= 1'b0;
      prev_q <= '0;
      arm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (setup_ph && !PWRITE) prdata_q <= rd_data;
      for (int i = 0; i < NUM_CH; i++)
        if (wr_commit && set_hit && idx == 6'(i)) set_q[i] <= PWDATA[DW-1:0];
      if (wr_commit && en_hit) enable_q <= PWDATA[NUM_CH-1:0];
      status_q <= (status_q & ~((wr_commit && st_hit) ? PWDATA[NUM_CH-1:0] : '0)) | chg;
      irq_q <= |(status_q & enable_q);
      prev_q <= mon_s;
      arm_q <= 1'b1;
    end
  end
endmodule
